// File: rtl/gpu_pkg.sv
// Shared constants and types for the compute core fetch path.
package gpu_pkg;

  // Scheduler (core_state) encodings seen by the fetch stage
  localparam logic [3:0] CORE_IDLE   = 4'b0000;
  localparam logic [3:0] CORE_FETCH  = 4'b0001;
  localparam logic [3:0] CORE_DECODE = 4'b0010;

  // Default program memory geometry
  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 16;

  // Fetcher FSM states
  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_WAIT    = 2'd1,
    F_FETCHED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped, one-instruction-per-line storage: combinational lookup,
// synchronous fill, and a flush that clears every valid bit at once.
module icache_array
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int LINES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 flush
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [DATA_BITS-1:0] data_q [LINES];

  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;

  assign rd_idx  = lookup_addr[IDX_BITS-1:0];
  assign wr_idx  = wr_addr[IDX_BITS-1:0];
  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == lookup_addr[ADDR_BITS-1:IDX_BITS]);
  assign rd_data = data_q[rd_idx];

  // Valid bits: flush takes priority over a fill landing on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload; only meaningful when the matching valid bit is set
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_addr[ADDR_BITS-1:IDX_BITS];
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/fetcher_icache.sv
// Instruction fetch stage with a small direct-mapped instruction cache.
// Memory handshake: mem_read_valid/mem_read_address are raised by this block
// and held unchanged until a cycle with mem_read_ready=1; that cycle transfers
// mem_read_data and the request drops on the same edge. A raised request is
// never withdrawn except by reset. mem_read_ready is ignored while no request
// is outstanding.
module fetcher_icache
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
  parameter int CACHE_LINES           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [3:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic                             request_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output fetch_state_t                     fetch_state
);

  fetch_state_t                     state_q;
  logic                             cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;
  logic                             fill_en;
  logic                             in_fetch;

  assign in_fetch    = (core_state == CORE_FETCH);
  // The fill always targets the held request address, never the live PC
  assign fill_en     = (state_q == F_WAIT) && mem_read_ready;
  assign fetch_state = state_q;

  icache_array #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (current_pc),
    .hit         (cache_hit),
    .rd_data     (cache_data),
    .wr_en       (fill_en),
    .wr_addr     (mem_read_address),
    .wr_data     (mem_read_data),
    .flush       (flush)
  );

  // Fetch FSM, memory request registers and registered instruction output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= F_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      request_ready    <= 1'b0;
      instruction      <= '0;
    end else begin
      case (state_q)
        F_IDLE: begin
          if (in_fetch) begin
            if (cache_hit) begin
              instruction   <= cache_data;
              request_ready <= 1'b1;
              state_q       <= F_FETCHED;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              state_q          <= F_WAIT;
            end
          end
        end
        F_WAIT: begin
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            // If the scheduler has left FETCH the data is kept but not announced
            if (in_fetch) begin
              request_ready <= 1'b1;
              state_q       <= F_FETCHED;
            end else begin
              state_q <= F_IDLE;
            end
          end
        end
        F_FETCHED: begin
          if (!in_fetch) begin
            request_ready <= 1'b0;
            state_q       <= F_IDLE;
          end
        end
        default: begin
          state_q <= F_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetcher_icache.sv
// Self-checking bench for fetcher_icache against a behavioural cache model.
module tb_fetcher_icache;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LINES = 4;

  localparam logic [3:0] ST_IDLE   = 4'b0000;
  localparam logic [3:0] ST_FETCH  = 4'b0001;
  localparam logic [3:0] ST_DECODE = 4'b0010;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_FETCHED = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]    core_state;
  logic [AW-1:0] current_pc;
  logic          flush;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic          request_ready;
  logic [DW-1:0] instruction;
  logic [1:0]    fetch_state;

  fetcher_icache #(
    .PROGRAM_MEM_ADDR_BITS (AW),
    .PROGRAM_MEM_DATA_BITS (DW),
    .CACHE_LINES           (LINES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .request_ready    (request_ready),
    .instruction      (instruction),
    .fetch_state      (fetch_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [DW-1:0] prog_mem [256];
  bit            model_valid [LINES];
  int            model_tag   [LINES];
  logic [DW-1:0] exp_q [$];   // expected instruction of the fetch in flight

  function automatic bit model_hit(input logic [AW-1:0] pc);
    int idx;
    idx = int'(pc) % LINES;
    return model_valid[idx] && (model_tag[idx] == int'(pc) / LINES);
  endfunction

  function automatic void model_fill(input logic [AW-1:0] pc);
    int idx;
    idx = int'(pc) % LINES;
    model_valid[idx] = 1'b1;
    model_tag[idx]   = int'(pc) / LINES;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
  endtask

  // One fetch as the scheduler would issue it; a miss is answered after
  // 'waits' stall cycles. Optionally pulses flush on the fill edge or has the
  // scheduler leave FETCH before the memory answers.
  task automatic do_fetch(input logic [AW-1:0] pc, input int waits,
                          input bit flush_on_fill, input bit abort, input string name);
    bit            exp_hit;
    logic [DW-1:0] exp_instr;
    exp_hit = model_hit(pc);
    exp_q.push_back(prog_mem[pc]);
    exp_instr = exp_q.pop_front();
    core_state = ST_FETCH;
    current_pc = pc;
    tick();
    if (exp_hit) begin
      checks++;
      if (request_ready !== 1'b1 || mem_read_valid !== 1'b0 || instruction !== exp_instr
          || fetch_state !== S_FETCHED) begin
        errors++;
        $display("FAIL %s hit: rr=%0b mrv=%0b instr=%h st=%0d, expected rr=1 mrv=0 instr=%h st=%0d",
                 name, request_ready, mem_read_valid, instruction, fetch_state, exp_instr, S_FETCHED);
      end
    end else begin
      checks++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== pc || request_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s req: mrv=%0b addr=%h rr=%0b, expected mrv=1 addr=%h rr=0",
                 name, mem_read_valid, mem_read_address, request_ready, pc);
      end
      if (abort) core_state = ST_IDLE;
      for (int w = 0; w < waits; w++) begin
        tick();
        checks++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== pc || request_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s hold%0d: mrv=%0b addr=%h rr=%0b, expected mrv=1 addr=%h rr=0",
                   name, w, mem_read_valid, mem_read_address, request_ready, pc);
        end
      end
      mem_read_ready = 1'b1;
      mem_read_data  = exp_instr;
      flush          = flush_on_fill;
      tick();
      mem_read_ready = 1'b0;
      mem_read_data  = DW'($urandom);
      flush          = 1'b0;
      if (flush_on_fill) model_flush();
      else model_fill(pc);
      checks++;
      if (mem_read_valid !== 1'b0 || instruction !== exp_instr || request_ready !== !abort
          || fetch_state !== (abort ? S_IDLE : S_FETCHED)) begin
        errors++;
        $display("FAIL %s fill: mrv=%0b instr=%h rr=%0b st=%0d, expected mrv=0 instr=%h rr=%0b st=%0d",
                 name, mem_read_valid, instruction, request_ready, fetch_state,
                 exp_instr, !abort, abort ? S_IDLE : S_FETCHED);
      end
    end
    if (!abort) begin
      // scheduler sees request_ready during this cycle, still in FETCH
      tick();
      checks++;
      if (request_ready !== 1'b1 || instruction !== exp_instr || mem_read_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s held: rr=%0b instr=%h mrv=%0b, expected rr=1 instr=%h mrv=0",
                 name, request_ready, instruction, mem_read_valid, exp_instr);
      end
      core_state = ST_DECODE;
      // ready strobes with no request outstanding must be ignored
      mem_read_ready = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (request_ready !== 1'b0 || instruction !== exp_instr || mem_read_valid !== 1'b0
          || fetch_state !== S_IDLE) begin
        errors++;
        $display("FAIL %s decode: rr=%0b instr=%h mrv=%0b st=%0d, expected rr=0 instr=%h mrv=0 st=0",
                 name, request_ready, instruction, mem_read_valid, fetch_state, exp_instr);
      end
    end
    core_state     = ST_IDLE;
    mem_read_ready = 1'($urandom_range(0, 1));
    tick();
    mem_read_ready = 1'b0;
    checks++;
    if (request_ready !== 1'b0 || instruction !== exp_instr || mem_read_valid !== 1'b0
        || fetch_state !== S_IDLE) begin
      errors++;
      $display("FAIL %s idle: rr=%0b instr=%h mrv=%0b st=%0d, expected rr=0 instr=%h mrv=0 st=0",
               name, request_ready, instruction, mem_read_valid, fetch_state, exp_instr);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (mem_read_valid !== 1'b0 || mem_read_address !== '0 || request_ready !== 1'b0
        || instruction !== '0 || fetch_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset: mrv=%0b addr=%h rr=%0b instr=%h st=%0d, expected all zero",
               mem_read_valid, mem_read_address, request_ready, instruction, fetch_state);
    end
    tick();
    tick();
    reset = 1'b1;
    model_flush();
    tick();
  endtask

  task automatic test_cold_miss();
    do_flush();
    do_fetch(8'h05, 3, 1'b0, 1'b0, "cold_miss");
  endtask

  task automatic test_hit();
    do_fetch(8'h05, 0, 1'b0, 1'b0, "hit");
  endtask

  task automatic test_conflict();
    do_fetch(8'h01, 1, 1'b0, 1'b0, "conflict_a");
    do_fetch(8'h05, 0, 1'b0, 1'b0, "conflict_b");
    do_fetch(8'h05, 0, 1'b0, 1'b0, "conflict_b_hit");
    do_fetch(8'h01, 2, 1'b0, 1'b0, "conflict_a_again");
  endtask

  task automatic test_flush_fill();
    do_fetch(8'h02, 1, 1'b1, 1'b0, "flush_fill");
    do_fetch(8'h02, 0, 1'b0, 1'b0, "flush_fill_refetch");
  endtask

  task automatic test_abort();
    do_fetch(8'h09, 2, 1'b0, 1'b1, "abort");
    do_fetch(8'h09, 0, 1'b0, 1'b0, "abort_refetch");
  endtask

  task automatic test_async_reset();
    do_fetch(8'h0E, 0, 1'b0, 1'b0, "pre_reset");
    do_flush();
    core_state = ST_FETCH;
    current_pc = 8'h0E;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_read_valid !== 1'b0 || request_ready !== 1'b0 || instruction !== '0
        || fetch_state !== S_IDLE) begin
      errors++;
      $display("FAIL async_reset: mrv=%0b rr=%0b instr=%h st=%0d, expected all zero",
               mem_read_valid, request_ready, instruction, fetch_state);
    end
    core_state = ST_IDLE;
    tick();
    reset = 1'b1;
    model_flush();
    tick();
    do_fetch(8'h0E, 1, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      do_fetch(AW'($urandom_range(0, 11)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  initial begin
    core_state     = ST_IDLE;
    current_pc     = '0;
    flush          = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    for (int i = 0; i < 256; i++) prog_mem[i] = DW'($urandom) | DW'(1);
    prog_mem[8'h05] = 16'h9ABC;
    for (int i = 0; i < LINES; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = 0;
    end
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_fill();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
